multicycle_ctrl: RTL and testbench
==================================

# multicycle_ctrl

Multicycle sequencer for the ARM-subset datapath. It decodes the latched instruction, evaluates the condition field against a stored NZCV register, and steps a 10-state FSM through fetch, decode, execute, memory and writeback. Each step drives the datapath mux selects, ALU operation and write enables, including the SLT result-select line. It sits beside the datapath and shares its clock and reset.

## Interface
- No parameters.
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- Instr  in  32  instruction register contents, valid from DECODE onward.
- ALUFlags  in  4  live ALU flags {N,Z,C,V}.
- PCWrite  out  1  PC register enable.
- IRWrite  out  1  instruction register enable.
- MemWrite  out  1  data memory write strobe.
- RegWrite  out  1  register file write enable.
- AdrSrc  out  1  memory address select: 0 = PC, 1 = ALUOut.
- ALUSrcA  out  1  SrcA select: 0 = register A, 1 = PC.
- ALUSrcB  out  2  SrcB select: 00 = register B, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  Result select: 00 = ALUOut, 01 = Data, 10 = ALUResult.
- ImmSrc  out  2  extend mode, equal to Instr[27:26].
- RegSrc  out  2  RA2/RA1 select: bit0 = (Op == 10), bit1 = (Op == 01).
- ALUControl  out  2  ALU operation: 00 ADD, 01 SUB, 10 AND, 11 ORR.
- wireSLT  out  1  active-low SLT result select. It is 0 only in ALUWB of an SLT.
- Flags  out  4  stored NZCV.
- State  out  4  current FSM state, for debug.

## Operation

Instruction fields:
- Op = Instr[27:26], Funct = Instr[25:20], Cond = Instr[31:28].
- I = Funct[5], cmd = Funct[4:1], S = Funct[0].
- cmd decode: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR, 1010 CMP, 1011 SLT.
- CMP and SLT use SUB. Any other cmd decodes as ADD with no writeback.

Condition evaluation (CondEx):
- Codes 0000–1110 evaluate as standard ARM: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL.
- Cond = 1111 gives CondEx = 0.

States and encodings: FETCH = 0, DECODE = 1, MEMADR = 2, MEMRD = 3, MEMWB = 4, MEMWR = 5, EXECR = 6, EXECI = 7, ALUWB = 8, BRANCH = 9.

Per-state outputs (all unlisted enables are 0, all unlisted selects are 0, wireSLT = 1):
- FETCH: IRWrite = 1, PCWrite = 1, ALUSrcA = 1, ALUSrcB = 10, ALU ADD, ResultSrc = 10.
- DECODE: ALUSrcA = 1, ALUSrcB = 10, ALU ADD, ResultSrc = 10.
- MEMADR: ALUSrcB = 01. ALU is ADD if Funct[3] = 1, else SUB.
- MEMRD: AdrSrc = 1.
- MEMWB: RegWrite = 1, ResultSrc = 01.
- MEMWR: AdrSrc = 1, MemWrite = 1.
- EXECR / EXECI: ALU per cmd. ALUSrcB = 00 (EXECR) or 01 (EXECI).
- ALUWB: RegWrite = 1, ResultSrc = 00.
  - For SLT, ALUWB keeps the EXEC operands and SUB, and drives wireSLT = 0, so the datapath writes 1 when ALUFlags[1] = 0.
- BRANCH: ALUSrcB = 01, ALU ADD, ResultSrc = 10, PCWrite = 1.

Transitions:
- FETCH → DECODE.
- DECODE:
  - CondEx = 0 → FETCH.
  - Op = 00 → EXECI if I = 1, else EXECR.
  - Op = 01 → MEMADR.
  - Op = 10 → BRANCH.
  - Op = 11 → FETCH, treated as a NOP.
- MEMADR → MEMRD if Funct[0] = 1 (load), else MEMWR.
- MEMRD → MEMWB. MEMWB → FETCH. MEMWR → FETCH.
- EXECR / EXECI → FETCH if cmd = CMP, else ALUWB.
- ALUWB → FETCH. BRANCH → FETCH.

Flags register:
- Loads ALUFlags at the end of EXECR/EXECI when S = 1, or when cmd = CMP.
- Holds its value otherwise, including when the instruction is not executed.

## Timing
- Reset:
  - On the first rising edge with reset = 1: State = FETCH, Flags = 0000.
  - Outputs are Moore-decoded, so the FETCH values apply during reset.
- Reset mid-instruction abandons the instruction. No write enable is asserted in the cycle after the reset edge, except FETCH's PCWrite and IRWrite.
- Cycle counts: LDR 5, STR 4, DP-with-writeback 4, CMP 3, B 3, not-executed 2, Op = 11 2.
- All outputs are combinational on State and Instr only. No output depends combinationally on ALUFlags.
  - The datapath's SLT mux alone consumes live ALUFlags.
- Flags changes are visible one cycle after the EXEC state that loads them.

## Test plan
- Reset held 2 cycles, then released → State = 0, Flags = 0000, PCWrite = IRWrite = 1 in the first cycle.
- ADD R1,R2,#5 (Instr = 0xE2821005) → states 0, 1, 7, 8, 0. RegWrite = 1 only in state 8. ALUSrcB = 01 in state 7.
- CMP R1,R1 then BEQ (Instr = 0x0A000002) → Flags = 0100 after CMP (3 cycles). BEQ takes states 0, 1, 9 with PCWrite = 1 in state 9.
- BNE with Z = 1 (Instr = 0x1A000002) → states 0, 1, 0. No PCWrite in DECODE.
- LDR R0,[R1,#4] (0xE5910004) → states 0, 1, 2, 3, 4. AdrSrc = 1 in state 3. ResultSrc = 01 with RegWrite in state 4.
- STR (0xE5810004) → MemWrite = 1 only in state 5.
- SLT (cmd 1011, I = 0) → in state 8: wireSLT = 0, ALUControl = 01, ALUSrcB = 00.
- Reset asserted during MEMWR → next state 0, MemWrite = 0 after the edge.

Source files
------------

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer: decodes Instr, gates on NZCV condition, steps a 10-state FSM and drives datapath controls.
// Latency: LDR 5, STR 4, DP with writeback 4, CMP 3, B 3, not-executed or Op=11 2 cycles; outputs are Moore-decoded.
// Backpressure: none; the FSM advances every cycle and the datapath is assumed always ready.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Instr,
  input  logic [3:0]  ALUFlags,
  output logic        PCWrite,
  output logic        IRWrite,
  output logic        MemWrite,
  output logic        RegWrite,
  output logic        AdrSrc,
  output logic        ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ImmSrc,
  output logic [1:0]  RegSrc,
  output logic [1:0]  ALUControl,
  output logic        wireSLT,
  output logic [3:0]  Flags,
  output logic [3:0]  State
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } state_t;

  // ALU operation codes as seen by the datapath
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_ORR = 2'b11;

  // Data-processing cmd encodings understood by this subset
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_ORR = 4'b1100;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_SLT = 4'b1011;

  state_t      state_q;
  state_t      state_d;
  logic [3:0]  flags_q;

  // Instruction fields
  logic [1:0]  op;
  logic [5:0]  funct;
  logic [3:0]  cond;
  logic        i_bit;
  logic [3:0]  cmd;
  logic        s_bit;

  assign op    = Instr[27:26];
  assign funct = Instr[25:20];
  assign cond  = Instr[31:28];
  assign i_bit = funct[5];
  assign cmd   = funct[4:1];
  assign s_bit = funct[0];

  // Register numbers and immediates belong to the datapath, not the sequencer
  logic unused_instr_bits;
  assign unused_instr_bits = ^Instr[19:0];

  // cmd decode results
  logic [1:0]  cmd_alu;
  logic        cmd_wb;
  logic        is_cmp;
  logic        is_slt;

  // Map the data-processing cmd to an ALU op and decide whether it writes a register
  always_comb begin
    cmd_alu = ALU_ADD;
    cmd_wb  = 1'b0;
    is_cmp  = 1'b0;
    is_slt  = 1'b0;
    case (cmd)
      CMD_ADD: begin cmd_alu = ALU_ADD; cmd_wb = 1'b1; end
      CMD_SUB: begin cmd_alu = ALU_SUB; cmd_wb = 1'b1; end
      CMD_AND: begin cmd_alu = ALU_AND; cmd_wb = 1'b1; end
      CMD_ORR: begin cmd_alu = ALU_ORR; cmd_wb = 1'b1; end
      CMD_CMP: begin cmd_alu = ALU_SUB; is_cmp = 1'b1; end
      CMD_SLT: begin cmd_alu = ALU_SUB; cmd_wb = 1'b1; is_slt = 1'b1; end
      // Unknown cmds still run the ALU as ADD but never write a register
      default: begin cmd_alu = ALU_ADD; cmd_wb = 1'b0; end
    endcase
  end

  // Stored flags, named for readability of the condition table
  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;
  logic cond_ex;

  assign flag_n = flags_q[3];
  assign flag_z = flags_q[2];
  assign flag_c = flags_q[1];
  assign flag_v = flags_q[0];

  // Evaluate the ARM condition code against the stored NZCV (never the live flags)
  always_comb begin
    cond_ex = 1'b0;
    case (cond)
      4'b0000: cond_ex = flag_z;                              // EQ
      4'b0001: cond_ex = ~flag_z;                             // NE
      4'b0010: cond_ex = flag_c;                              // CS
      4'b0011: cond_ex = ~flag_c;                             // CC
      4'b0100: cond_ex = flag_n;                              // MI
      4'b0101: cond_ex = ~flag_n;                             // PL
      4'b0110: cond_ex = flag_v;                              // VS
      4'b0111: cond_ex = ~flag_v;                             // VC
      4'b1000: cond_ex = flag_c & ~flag_z;                    // HI
      4'b1001: cond_ex = ~flag_c | flag_z;                    // LS
      4'b1010: cond_ex = (flag_n == flag_v);                  // GE
      4'b1011: cond_ex = (flag_n != flag_v);                  // LT
      4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);        // GT
      4'b1101: cond_ex = flag_z | (flag_n != flag_v);         // LE
      4'b1110: cond_ex = 1'b1;                                // AL
      default: cond_ex = 1'b0;                                // 1111 never executes
    endcase
  end

  // Flags load at the end of an EXEC state for S-suffixed ops and for CMP
  logic flags_ld;
  assign flags_ld = ((state_q == EXECR) || (state_q == EXECI)) && (s_bit || is_cmp);

  // State register and NZCV register; reset abandons any instruction in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FETCH;
      flags_q <= 4'b0000;
    end else begin
      state_q <= state_d;
      if (flags_ld) begin
        flags_q <= ALUFlags;
      end
    end
  end

  // Next-state logic and Moore control outputs, decoded from state and Instr only
  always_comb begin
    state_d    = FETCH;
    PCWrite    = 1'b0;
    IRWrite    = 1'b0;
    MemWrite   = 1'b0;
    RegWrite   = 1'b0;
    AdrSrc     = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    ResultSrc  = 2'b00;
    ALUControl = ALU_ADD;
    wireSLT    = 1'b1;

    case (state_q)
      FETCH: begin
        // Fetch the instruction and advance PC by 4 in the same cycle
        IRWrite   = 1'b1;
        PCWrite   = 1'b1;
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        state_d   = DECODE;
      end
      DECODE: begin
        // PC+8 is formed here so branches and R15 reads see it
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        if (!cond_ex) begin
          state_d = FETCH;
        end else begin
          case (op)
            2'b00:   state_d = i_bit ? EXECI : EXECR;
            2'b01:   state_d = MEMADR;
            2'b10:   state_d = BRANCH;
            default: state_d = FETCH;
          endcase
        end
      end
      MEMADR: begin
        // U bit selects whether the offset is added or subtracted
        ALUSrcB    = 2'b01;
        ALUControl = funct[3] ? ALU_ADD : ALU_SUB;
        state_d    = funct[0] ? MEMRD : MEMWR;
      end
      MEMRD: begin
        AdrSrc  = 1'b1;
        state_d = MEMWB;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        ResultSrc = 2'b01;
        state_d   = FETCH;
      end
      MEMWR: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
        state_d  = FETCH;
      end
      EXECR, EXECI: begin
        ALUSrcB    = (state_q == EXECI) ? 2'b01 : 2'b00;
        ALUControl = cmd_alu;
        state_d    = is_cmp ? FETCH : ALUWB;
      end
      ALUWB: begin
        RegWrite  = cmd_wb;
        ResultSrc = 2'b00;
        if (is_slt) begin
          // Re-run the subtract so the datapath can pick 1/0 from the live carry
          ALUSrcB    = i_bit ? 2'b01 : 2'b00;
          ALUControl = ALU_SUB;
          wireSLT    = 1'b0;
        end
        state_d = FETCH;
      end
      BRANCH: begin
        ALUSrcB    = 2'b01;
        ALUControl = ALU_ADD;
        ResultSrc  = 2'b10;
        PCWrite    = 1'b1;
        state_d    = FETCH;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

  assign ImmSrc = op;
  assign RegSrc = {(op == 2'b01), (op == 2'b10)};
  assign Flags  = flags_q;
  assign State  = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed instructions then random ones checked against a reference model.
// Latency: per-instruction state sequences derived from instruction class and stored flags.
// Backpressure: none; stimulus advances one cycle at a time.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] Instr;
  logic [3:0]  ALUFlags;
  logic        PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA, wireSLT;
  logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
  logic [3:0]  Flags, State;

  multicycle_ctrl dut (
    .clk        (clk),
    .reset      (reset),
    .Instr      (Instr),
    .ALUFlags   (ALUFlags),
    .PCWrite    (PCWrite),
    .IRWrite    (IRWrite),
    .MemWrite   (MemWrite),
    .RegWrite   (RegWrite),
    .AdrSrc     (AdrSrc),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ResultSrc  (ResultSrc),
    .ImmSrc     (ImmSrc),
    .RegSrc     (RegSrc),
    .ALUControl (ALUControl),
    .wireSLT    (wireSLT),
    .Flags      (Flags),
    .State      (State)
  );

  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  // Model of the stored NZCV and the expected state walk of the current instruction
  logic [3:0] flags_m;
  int         exp_q[$];

  logic [12:0] ctrl_obs;
  assign ctrl_obs = {PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
                     ALUSrcB, ResultSrc, ALUControl, wireSLT};

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ARM conditions come in true/inverted pairs: c[3:1] picks the test, c[0] inverts it
  function automatic bit cond_holds(input logic [3:0] c, input logic [3:0] f);
    bit n, z, cy, v, r;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    case (c[3:1])
      3'd0:    r = z;
      3'd1:    r = cy;
      3'd2:    r = n;
      3'd3:    r = v;
      3'd4:    r = cy && !z;
      3'd5:    r = (n == v);
      3'd6:    r = !z && (n == v);
      default: r = 1'b1;
    endcase
    if (c == 4'hF) return 1'b0;
    return c[0] ? !r : r;
  endfunction

  function automatic logic [1:0] alu_of(input logic [3:0] cmd);
    case (cmd)
      4'b0010, 4'b1010, 4'b1011: return 2'b01;
      4'b0000:                   return 2'b10;
      4'b1100:                   return 2'b11;
      default:                   return 2'b00;
    endcase
  endfunction

  function automatic bit writes_back(input logic [3:0] cmd);
    return (cmd == 4'b0100) || (cmd == 4'b0010) || (cmd == 4'b0000) ||
           (cmd == 4'b1100) || (cmd == 4'b1011);
  endfunction

  // Expected state walk per instruction class
  task automatic build_seq(input logic [31:0] ins);
    logic [1:0] op;
    int         ex;
    op = ins[27:26];
    exp_q.delete();
    exp_q.push_back(0);
    exp_q.push_back(1);
    if (cond_holds(ins[31:28], flags_m)) begin
      if (op == 2'b10) begin
        exp_q.push_back(9);
      end else if (op == 2'b01) begin
        exp_q.push_back(2);
        if (ins[20]) begin
          exp_q.push_back(3);
          exp_q.push_back(4);
        end else begin
          exp_q.push_back(5);
        end
      end else if (op == 2'b00) begin
        ex = ins[25] ? 7 : 6;
        exp_q.push_back(ex);
        if (ins[24:21] != 4'b1010) exp_q.push_back(8);
      end
    end
  endtask

  // Control word {PCW,IRW,MemW,RegW,AdrSrc,SrcA,SrcB,ResultSrc,ALUCtl,wireSLT} per state
  function automatic logic [12:0] exp_ctrl(input int st, input logic [31:0] ins);
    logic pc, ir, mw, rw, adr, sa, slt_n;
    logic [1:0] sb, rs, ac;
    logic [3:0] cmd;
    pc = 0; ir = 0; mw = 0; rw = 0; adr = 0; sa = 0; slt_n = 1;
    sb = 0; rs = 0; ac = 0;
    cmd = ins[24:21];
    case (st)
      0: begin pc = 1; ir = 1; sa = 1; sb = 2'b10; rs = 2'b10; end
      1: begin sa = 1; sb = 2'b10; rs = 2'b10; end
      2: begin sb = 2'b01; ac = ins[23] ? 2'b00 : 2'b01; end
      3: adr = 1;
      4: begin rw = 1; rs = 2'b01; end
      5: begin adr = 1; mw = 1; end
      6: ac = alu_of(cmd);
      7: begin sb = 2'b01; ac = alu_of(cmd); end
      8: begin
        rw = writes_back(cmd);
        if (cmd == 4'b1011) begin
          sb = ins[25] ? 2'b01 : 2'b00; ac = 2'b01; slt_n = 0;
        end
      end
      9: begin sb = 2'b01; rs = 2'b10; pc = 1; end
      default: ;
    endcase
    return {pc, ir, mw, rw, adr, sa, sb, rs, ac, slt_n};
  endfunction

  // Called #1 after a rising edge with the DUT in FETCH; walks one instruction
  task automatic run_instr(input logic [31:0] ins, input bit force_f, input logic [3:0] ff,
                           input bit reset_at_last);
    int st;
    build_seq(ins);
    for (int k = 0; k < exp_q.size(); k++) begin
      st = exp_q[k];
      if (k == 0) Instr = ins;
      ALUFlags = force_f ? ff : 4'($urandom);
      #4;
      check_val($sformatf("state[%0d] instr %08h", k, ins), {28'd0, State}, st);
      check_val($sformatf("flags[%0d] instr %08h", k, ins), {28'd0, Flags}, {28'd0, flags_m});
      check_val($sformatf("ctrl st%0d instr %08h", st, ins), {19'd0, ctrl_obs}, {19'd0, exp_ctrl(st, ins)});
      check_val($sformatf("imm/regsrc instr %08h", ins), {28'd0, ImmSrc, RegSrc},
                {28'd0, ins[27:26], ins[27:26] == 2'b01, ins[27:26] == 2'b10});
      if ((st == 6 || st == 7) && (ins[20] || ins[24:21] == 4'b1010)) flags_m = ALUFlags;
      if (reset_at_last && k == exp_q.size() - 1) reset = 1'b1;
      @(posedge clk);
      #1;
    end
    if (reset_at_last) begin
      flags_m = 4'b0000;
      check_val("reset mid-instr state", {28'd0, State}, 32'd0);
      check_val("reset mid-instr memwrite", {31'd0, MemWrite}, 32'd0);
      check_val("reset mid-instr flags", {28'd0, Flags}, 32'd0);
      reset = 1'b0;
    end
  endtask

  initial begin
    logic [3:0]  cmds [6];
    logic [3:0]  cond, cmd;
    logic [31:0] ins;
    cmds[0] = 4'b0100; cmds[1] = 4'b0010; cmds[2] = 4'b0000;
    cmds[3] = 4'b1100; cmds[4] = 4'b1010; cmds[5] = 4'b1011;

    reset    = 1'b1;
    Instr    = 32'd0;
    ALUFlags = 4'hF;
    flags_m  = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset state", {28'd0, State}, 32'd0);
    check_val("reset flags", {28'd0, Flags}, 32'd0);
    check_val("reset pcwrite/irwrite", {30'd0, PCWrite, IRWrite}, 32'd3);
    reset = 1'b0;

    run_instr(32'hE2821005, 0, 4'h0, 0);      // ADD R1,R2,#5
    run_instr(32'hE1510001, 1, 4'b0100, 0);   // CMP R1,R1 -> Z
    run_instr(32'h0A000002, 0, 4'h0, 0);      // BEQ taken
    run_instr(32'h1A000002, 0, 4'h0, 0);      // BNE not executed
    run_instr(32'hE5910004, 0, 4'h0, 0);      // LDR R0,[R1,#4]
    run_instr(32'hE1612003, 0, 4'h0, 0);      // SLT R2,R1,R3
    run_instr(32'hE5810004, 0, 4'h0, 1);      // STR, reset in MEMWR

    for (int n = 0; n < 250; n++) begin
      cond = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hE;
      cmd  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : cmds[$urandom_range(0, 5)];
      ins  = {cond, 2'($urandom), 1'($urandom), cmd, 1'($urandom), 20'($urandom)};
      run_instr(ins, 0, 4'h0, 0);
    end

    #4;
    check_val("final state", {28'd0, State}, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
